hamming_uart_sequencer: RTL and testbench

- Sequences the Hamming codec between the UART RX FIFO and the UART TX FIFO.
- Pops ASCII '0'/'1' characters from the RX FIFO and assembles them MSB-first into a DATA_W-bit word.
- Starts the codec with that word and waits for the codec result.
- Writes the CODE_W-bit result back to the TX FIFO as ASCII '0'/'1' characters, followed by CR LF.
- Sits between the two FIFO instances and the encoder/decoder core in the top level.

---
 rtl/hamming_uart_sequencer.sv | 143 ++++++++++++++
 tb/tb_hamming_uart_sequencer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hamming_uart_sequencer.sv
// Moves ASCII bit-characters from the UART RX FIFO into the Hamming codec and
// streams the codec result back out through the UART TX FIFO, terminated by CR LF.
module hamming_uart_sequencer #(
  parameter int DATA_W  = 8,
  parameter int CODE_W  = 12,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_empty,
  input  logic [7:0]        rx_r_data,
  output logic              rx_rd,
  input  logic              tx_full,
  output logic [7:0]        tx_w_data,
  output logic              tx_wr,
  output logic [DATA_W-1:0] cdc_data,
  output logic              cdc_start,
  input  logic              cdc_done,
  input  logic [CODE_W-1:0] cdc_result,
  output logic              busy,
  output logic [7:0]        bad_char_cnt
);

  localparam int BC_W = $clog2(DATA_W + 1);
  localparam int EC_W = $clog2(CODE_W + 1);
  localparam int TO_W = $clog2(TIMEOUT + 1);

  // state | meaning: COLLECT gather chars | START pulse codec | WAIT await done/timeout
  // EMIT stream result bits | ERR emit '!' | CR emit 0x0D | LF emit 0x0A
  typedef enum logic [2:0] {
    S_COLLECT, S_START, S_WAIT, S_EMIT, S_ERR, S_CR, S_LF
  } state_t;

  state_t              state_q, state_d;
  logic [BC_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]   asm_q, asm_d;
  logic [DATA_W-1:0]   cdc_data_q, cdc_data_d;
  logic [7:0]          bad_q, bad_d;
  logic [TO_W-1:0]     to_q, to_d;
  logic [CODE_W-1:0]   emit_q, emit_d;
  logic [EC_W-1:0]     ecnt_q, ecnt_d;
  logic                is_bit;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_COLLECT;
      bit_cnt_q  <= '0;
      asm_q      <= '0;
      cdc_data_q <= '0;
      bad_q      <= '0;
      to_q       <= '0;
      emit_q     <= '0;
      ecnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      asm_q      <= asm_d;
      cdc_data_q <= cdc_data_d;
      bad_q      <= bad_d;
      to_q       <= to_d;
      emit_q     <= emit_d;
      ecnt_q     <= ecnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    asm_d      = asm_q;
    cdc_data_d = cdc_data_q;
    bad_d      = bad_q;
    to_d       = to_q;
    emit_d     = emit_q;
    ecnt_d     = ecnt_q;
    tx_w_data  = 8'h00;
    is_bit     = (rx_r_data == 8'h30) || (rx_r_data == 8'h31);

    // Strobes are masked during reset so every output shows its reset value.
    rx_rd = (state_q == S_COLLECT) && !rx_empty && !reset;
    tx_wr = ((state_q == S_EMIT) || (state_q == S_ERR) ||
             (state_q == S_CR)   || (state_q == S_LF)) && !tx_full && !reset;

    unique case (state_q)
      S_COLLECT: begin
        if (rx_rd) begin
          if (is_bit) begin
            asm_d = {asm_q[DATA_W-2:0], rx_r_data[0]};
            if (bit_cnt_q == BC_W'(DATA_W - 1)) begin
              cdc_data_d = asm_d;
              bit_cnt_d  = '0;
              state_d    = S_START;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end else if (bad_q != 8'hFF) begin
            bad_d = bad_q + 8'd1;
          end
        end
      end
      S_START: begin
        to_d    = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cdc_done) begin
          emit_d  = cdc_result;
          ecnt_d  = '0;
          state_d = S_EMIT;
        end else begin
          to_d = to_q + 1'b1;
          if (to_d == TO_W'(TIMEOUT)) state_d = S_ERR;
        end
      end
      S_EMIT: begin
        tx_w_data = emit_q[CODE_W-1] ? 8'h31 : 8'h30;
        if (tx_wr) begin
          emit_d = {emit_q[CODE_W-2:0], 1'b0};
          ecnt_d = ecnt_q + 1'b1;
          if (ecnt_q == EC_W'(CODE_W - 1)) state_d = S_CR;
        end
      end
      S_ERR: begin
        tx_w_data = 8'h21;
        if (tx_wr) state_d = S_CR;
      end
      S_CR: begin
        tx_w_data = 8'h0D;
        if (tx_wr) state_d = S_LF;
      end
      S_LF: begin
        tx_w_data = 8'h0A;
        if (tx_wr) state_d = S_COLLECT;
      end
      default: state_d = S_COLLECT;
    endcase
  end

  assign cdc_data     = cdc_data_q;
  assign cdc_start    = (state_q == S_START) && !reset;
  assign busy         = (state_q != S_COLLECT) && !reset;
  assign bad_char_cnt = bad_q;

endmodule

// File: tb/tb_hamming_uart_sequencer.sv
// Bench for hamming_uart_sequencer: FIFO and codec models on the falling edge,
// scoreboard queues for expected codec words and TX bytes.
module tb_hamming_uart_sequencer;
  localparam int DATA_W  = 8;
  localparam int CODE_W  = 12;
  localparam int TIMEOUT = 255;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              rx_empty = 1'b1;
  logic [7:0]        rx_r_data = 8'h00;
  logic              rx_rd;
  logic              tx_full = 1'b0;
  logic [7:0]        tx_w_data;
  logic              tx_wr;
  logic [DATA_W-1:0] cdc_data;
  logic              cdc_start;
  logic              cdc_done = 1'b0;
  logic [CODE_W-1:0] cdc_result = '0;
  logic              busy;
  logic [7:0]        bad_char_cnt;

  hamming_uart_sequencer #(.DATA_W(DATA_W), .CODE_W(CODE_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .rx_empty(rx_empty), .rx_r_data(rx_r_data), .rx_rd(rx_rd),
    .tx_full(tx_full), .tx_w_data(tx_w_data), .tx_wr(tx_wr), .cdc_data(cdc_data),
    .cdc_start(cdc_start), .cdc_done(cdc_done), .cdc_result(cdc_result), .busy(busy),
    .bad_char_cnt(bad_char_cnt)
  );

  always #5 clk = ~clk;

  logic [7:0]        rx_q[$];
  logic [7:0]        exp_tx[$];
  logic [DATA_W-1:0] exp_data[$];

  int pass_cnt = 0, tot_cnt = 0;
  int rd_cnt = 0, wr_cnt = 0, start_cnt = 0, cyc = 0;
  int first_wr = -1, last_wr = -1, start_cyc = 0, bang_cyc = 0, txn_wr = 0;
  int full_hold = 0, done_dly = 0;
  bit pop_pend = 0, codec_en = 1, bp_arm = 0, inj_done = 0;
  logic [CODE_W-1:0] codec_res = '0;

  // Inputs change on the falling edge; DUT outputs are sampled 1 ns later.
  always @(negedge clk) begin
    logic [7:0] e;
    logic [DATA_W-1:0] ed;
    cyc++;
    if (pop_pend && rx_q.size() > 0) void'(rx_q.pop_front());
    pop_pend  = 0;
    rx_empty  = (rx_q.size() == 0);
    rx_r_data = rx_empty ? 8'h00 : rx_q[0];
    tx_full   = (full_hold > 0);
    if (full_hold > 0) full_hold--;
    cdc_done = 1'b0;
    if (inj_done) begin cdc_done = 1'b1; cdc_result = 12'hFFF; inj_done = 0; end
    if (done_dly > 0) begin
      done_dly--;
      if (done_dly == 0) begin cdc_done = 1'b1; cdc_result = codec_res; end
    end
    #1;
    if (rx_rd === 1'b1) begin pop_pend = 1; rd_cnt++; end
    if (tx_full) begin
      tot_cnt++;
      if (tx_wr !== 1'b0) $display("FAIL tx_wr_while_full: got %b expected 0", tx_wr);
      else pass_cnt++;
    end
    if (tx_wr === 1'b1) begin
      wr_cnt++;
      if (first_wr < 0) first_wr = cyc;
      last_wr = cyc;
      if (tx_w_data == 8'h21) bang_cyc = cyc;
      tot_cnt++;
      if (exp_tx.size() == 0) $display("FAIL tx_unexpected: got %h expected no write", tx_w_data);
      else begin
        e = exp_tx.pop_front();
        if (tx_w_data !== e) $display("FAIL tx_byte: got %h expected %h", tx_w_data, e);
        else pass_cnt++;
      end
      txn_wr++;
      if (bp_arm && txn_wr == 4) begin full_hold = 5; bp_arm = 0; end
    end
    if (cdc_start === 1'b1) begin
      start_cnt++;
      start_cyc = cyc;
      tot_cnt++;
      if (exp_data.size() == 0) $display("FAIL cdc_start_unexpected: got %h expected no start", cdc_data);
      else begin
        ed = exp_data.pop_front();
        if (cdc_data !== ed) $display("FAIL cdc_data: got %h expected %h", cdc_data, ed);
        else pass_cnt++;
      end
      if (codec_en) done_dly = 3;
    end
  end

  // Pushes characters into the RX model; expect_out adds scoreboard entries per full word.
  task automatic send_str(input string s, input bit expect_out);
    logic [7:0] c;
    logic [DATA_W-1:0] w = '0;
    int n = 0;
    for (int i = 0; i < s.len(); i++) begin
      c = s[i];
      rx_q.push_back(c);
      if (c == 8'h30 || c == 8'h31) begin
        w = {w[DATA_W-2:0], (c == 8'h31)};
        n++;
        if (n == DATA_W) begin
          if (expect_out) begin
            exp_data.push_back(w);
            if (codec_en)
              for (int b = CODE_W - 1; b >= 0; b--) exp_tx.push_back(codec_res[b] ? 8'h31 : 8'h30);
            else
              exp_tx.push_back(8'h21);
            exp_tx.push_back(8'h0D);
            exp_tx.push_back(8'h0A);
          end
          n = 0;
        end
      end
    end
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #2;
      if (!busy && !pop_pend && rx_q.size() == 0 && exp_tx.size() == 0 && exp_data.size() == 0) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tot_cnt++;
    if ({rx_rd, tx_wr, cdc_start, busy} !== 4'b0000)
      $display("FAIL reset_strobes: got %b expected 0000", {rx_rd, tx_wr, cdc_start, busy});
    else pass_cnt++;
    tot_cnt++;
    if ({cdc_data, bad_char_cnt, tx_w_data} !== '0)
      $display("FAIL reset_values: got %h/%h/%h expected 0/0/0", cdc_data, bad_char_cnt, tx_w_data);
    else pass_cnt++;
    reset = 1'b0;
  endtask

  task automatic test_basic;
    bit ok;
    int rd0 = rd_cnt, st0 = start_cnt, wr0 = wr_cnt;
    @(posedge clk); #2;
    codec_en = 1; codec_res = 12'hA5C; first_wr = -1; txn_wr = 0;
    send_str("10110010", 1);
    wait_idle(1000, ok);
    tot_cnt++; if (!ok) $display("FAIL basic_idle: got timeout expected idle"); else pass_cnt++;
    tot_cnt++; if (rd_cnt - rd0 != 8) $display("FAIL basic_rd: got %0d expected 8", rd_cnt - rd0); else pass_cnt++;
    tot_cnt++; if (start_cnt - st0 != 1) $display("FAIL basic_start: got %0d expected 1", start_cnt - st0); else pass_cnt++;
    tot_cnt++; if (wr_cnt - wr0 != 14) $display("FAIL basic_wr: got %0d expected 14", wr_cnt - wr0); else pass_cnt++;
    tot_cnt++; if (last_wr - first_wr != 13) $display("FAIL basic_gap: got %0d expected 13", last_wr - first_wr); else pass_cnt++;
  endtask

  task automatic test_bad_chars;
    bit ok;
    int rd0 = rd_cnt;
    @(posedge clk); #2;
    codec_res = 12'h3C5;
    send_str("1x01 0110a1", 1);
    wait_idle(1000, ok);
    tot_cnt++; if (!ok) $display("FAIL bad_idle: got timeout expected idle"); else pass_cnt++;
    tot_cnt++; if (bad_char_cnt !== 8'd3) $display("FAIL bad_cnt: got %0d expected 3", bad_char_cnt); else pass_cnt++;
    tot_cnt++; if (rd_cnt - rd0 != 11) $display("FAIL bad_rd: got %0d expected 11", rd_cnt - rd0); else pass_cnt++;
  endtask

  task automatic test_backpressure;
    bit ok;
    int wr0 = wr_cnt;
    @(posedge clk); #2;
    codec_res = 12'hF0F; first_wr = -1; txn_wr = 0; bp_arm = 1;
    send_str("01010101", 1);
    wait_idle(1000, ok);
    tot_cnt++; if (!ok) $display("FAIL bp_idle: got timeout expected idle"); else pass_cnt++;
    tot_cnt++; if (wr_cnt - wr0 != 14) $display("FAIL bp_wr: got %0d expected 14", wr_cnt - wr0); else pass_cnt++;
    tot_cnt++; if (last_wr - first_wr != 18) $display("FAIL bp_span: got %0d expected 18", last_wr - first_wr); else pass_cnt++;
  endtask

  task automatic test_timeout;
    bit ok;
    int wr0;
    @(posedge clk); #2;
    codec_en = 0;
    send_str("11110000", 1);
    wait_idle(1000, ok);
    tot_cnt++; if (!ok) $display("FAIL to_idle: got timeout expected idle"); else pass_cnt++;
    tot_cnt++;
    if (bang_cyc - start_cyc != TIMEOUT + 1)
      $display("FAIL to_latency: got %0d expected %0d", bang_cyc - start_cyc, TIMEOUT + 1);
    else pass_cnt++;
    wr0 = wr_cnt;
    inj_done = 1;
    repeat (20) @(posedge clk);
    #2;
    tot_cnt++; if (wr_cnt != wr0) $display("FAIL to_stale_done: got %0d writes expected 0", wr_cnt - wr0); else pass_cnt++;
    tot_cnt++; if (busy !== 1'b0) $display("FAIL to_stale_busy: got %b expected 0", busy); else pass_cnt++;
    codec_en = 1;
  endtask

  task automatic test_saturation;
    bit ok;
    int st0 = start_cnt, rd0 = rd_cnt;
    @(posedge clk); #2;
    for (int i = 0; i < 300; i++) rx_q.push_back(8'h41);
    wait_idle(1000, ok);
    tot_cnt++; if (!ok) $display("FAIL sat_idle: got timeout expected idle"); else pass_cnt++;
    tot_cnt++; if (bad_char_cnt !== 8'd255) $display("FAIL sat_cnt: got %0d expected 255", bad_char_cnt); else pass_cnt++;
    tot_cnt++; if (start_cnt != st0) $display("FAIL sat_start: got %0d expected 0", start_cnt - st0); else pass_cnt++;
    tot_cnt++; if (rd_cnt - rd0 != 300) $display("FAIL sat_rd: got %0d expected 300", rd_cnt - rd0); else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    bit ok;
    @(posedge clk); #2;
    send_str("10110", 0);
    wait_idle(100, ok);
    tot_cnt++; if (!ok) $display("FAIL rm_partial: got timeout expected idle"); else pass_cnt++;
    codec_res = 12'h123;
    reset = 1'b1;
    send_str("00001111", 1);
    @(posedge clk); #1;
    tot_cnt++;
    if ({rx_rd, tx_wr, cdc_start, busy} !== 4'b0000)
      $display("FAIL rm_strobes: got %b expected 0000", {rx_rd, tx_wr, cdc_start, busy});
    else pass_cnt++;
    tot_cnt++;
    if ({cdc_data, bad_char_cnt, tx_w_data} !== '0)
      $display("FAIL rm_values: got %h/%h/%h expected 0/0/0", cdc_data, bad_char_cnt, tx_w_data);
    else pass_cnt++;
    reset = 1'b0;
    wait_idle(1000, ok);
    tot_cnt++; if (!ok) $display("FAIL rm_idle: got timeout expected idle"); else pass_cnt++;
    tot_cnt++; if (cdc_data !== 8'h0F) $display("FAIL rm_data: got %h expected 0f", cdc_data); else pass_cnt++;
    tot_cnt++; if (bad_char_cnt !== 8'd0) $display("FAIL rm_bad: got %0d expected 0", bad_char_cnt); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bad_chars();
    test_backpressure();
    test_timeout();
    test_saturation();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish before 1ms");
    $fatal(1, "watchdog expired");
  end

endmodule
